// File: rtl/router_pkt_src.sv
// Packet source for the 1xN router: emits header, payload and parity
// with busy back-pressure, packet counting and parity-error injection.
module router_pkt_src #(
  parameter int          DATA_WIDTH = 8,
  parameter int          ADDR_WIDTH = 2,
  parameter int          NUM_DEST   = 3,
  parameter int          GAP_CYCLES = 1,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             start,
  input  logic [ADDR_WIDTH-1:0]            cmd_addr,
  input  logic [DATA_WIDTH-ADDR_WIDTH-1:0] cmd_len,
  input  logic                             cmd_mode,
  input  logic                             cmd_corrupt,
  input  logic                             busy,
  output logic                             pkt_valid,
  output logic [DATA_WIDTH-1:0]            pkt_data,
  output logic                             ready,
  output logic                             done,
  output logic                             cmd_err,
  output logic [15:0]                      pkt_count
);
  localparam int DW = DATA_WIDTH;
  localparam int LW = DATA_WIDTH - ADDR_WIDTH;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_PAYLOAD,
    S_PARITY,
    S_GAP
  } state_t;

  state_t          state_q, state_d;
  logic            pkt_valid_q, pkt_valid_d;
  logic [DW-1:0]   pkt_data_q, pkt_data_d;
  logic            ready_q, ready_d;
  logic            done_q, done_d;
  logic            cmd_err_q, cmd_err_d;
  logic [15:0]     pkt_count_q, pkt_count_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [DW-1:0]   inc_q, inc_d;
  logic [DW-1:0]   acc_q, acc_d;
  logic [LW-1:0]   cnt_q, cnt_d;
  logic            mode_q, mode_d;
  logic            corrupt_q, corrupt_d;
  logic [GW-1:0]   gap_q, gap_d;

  logic [15:0]     lfsr_nx;
  logic [DW-1:0]   inc_nx;
  logic [DW-1:0]   acc_nx;
  logic            cmd_bad;

  // Galois form of x^16+x^14+x^13+x^11+1
  assign lfsr_nx = {1'b0, lfsr_q[15:1]}
                 ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  assign inc_nx  = inc_q + DW'(1);
  assign acc_nx  = acc_q ^ pkt_data_q;
  assign cmd_bad = (cmd_len == '0)
                || (int'(cmd_addr) >= NUM_DEST);

  always_comb begin
    state_d     = state_q;
    pkt_valid_d = pkt_valid_q;
    pkt_data_d  = pkt_data_q;
    done_d      = 1'b0;
    cmd_err_d   = 1'b0;
    pkt_count_d = pkt_count_q;
    lfsr_d      = lfsr_q;
    inc_d       = inc_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    corrupt_d   = corrupt_q;
    gap_d       = gap_q;
    unique case (state_q)
      S_IDLE: begin
        pkt_valid_d = 1'b0;
        pkt_data_d  = '0;
        if (start && cmd_bad) begin
          cmd_err_d = 1'b1;
        end else if (start) begin
          state_d     = S_HEADER;
          pkt_valid_d = 1'b1;
          pkt_data_d  = {cmd_len, cmd_addr};
          acc_d       = {cmd_len, cmd_addr};
          cnt_d       = cmd_len;
          mode_d      = cmd_mode;
          corrupt_d   = cmd_corrupt;
        end
      end
      S_HEADER: begin
        if (!busy) begin
          state_d    = S_PAYLOAD;
          inc_d      = DW'(1);
          pkt_data_d = mode_q ? DW'(1)
                              : lfsr_q[DW-1:0];
        end
      end
      S_PAYLOAD: begin
        if (!busy) begin
          acc_d = acc_nx;
          cnt_d = cnt_q - LW'(1);
          inc_d = inc_nx;
          if (!mode_q) lfsr_d = lfsr_nx;
          if (cnt_q == LW'(1)) begin
            state_d     = S_PARITY;
            pkt_valid_d = 1'b0;
            pkt_data_d  = acc_nx
                        ^ {{(DW-1){1'b0}}, corrupt_q};
          end else begin
            pkt_data_d = mode_q ? inc_nx
                                : lfsr_nx[DW-1:0];
          end
        end
      end
      S_PARITY: begin
        if (!busy) begin
          done_d      = 1'b1;
          pkt_count_d = pkt_count_q + 16'd1;
          pkt_data_d  = '0;
          if (GAP_CYCLES == 0) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_GAP;
            gap_d   = GW'(GAP_CYCLES - 1);
          end
        end
      end
      S_GAP: begin
        if (gap_q == '0) state_d = S_IDLE;
        else             gap_d   = gap_q - GW'(1);
      end
      default: begin
        state_d     = S_IDLE;
        pkt_valid_d = 1'b0;
        pkt_data_d  = '0;
      end
    endcase
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pkt_valid_q <= 1'b0;
      pkt_data_q  <= '0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      cmd_err_q   <= 1'b0;
      pkt_count_q <= '0;
      lfsr_q      <= SEED;
      inc_q       <= DW'(1);
      acc_q       <= '0;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      corrupt_q   <= 1'b0;
      gap_q       <= '0;
    end else begin
      state_q     <= state_d;
      pkt_valid_q <= pkt_valid_d;
      pkt_data_q  <= pkt_data_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      cmd_err_q   <= cmd_err_d;
      pkt_count_q <= pkt_count_d;
      lfsr_q      <= lfsr_d;
      inc_q       <= inc_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      corrupt_q   <= corrupt_d;
      gap_q       <= gap_d;
    end
  end

  assign pkt_valid = pkt_valid_q;
  assign pkt_data  = pkt_data_q;
  assign ready     = ready_q;
  assign done      = done_q;
  assign cmd_err   = cmd_err_q;
  assign pkt_count = pkt_count_q;
endmodule

// File: tb/tb_router_pkt_src.sv
// Bench for router_pkt_src: packet-list reference model checked every
// cycle, directed scenarios with literal values, then random traffic.
module tb_router_pkt_src;
  localparam int NUM_DEST = 3;
  localparam int GAP      = 1;
  localparam logic [15:0] SEED = 16'hACE1;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] cmd_addr;
  logic [5:0] cmd_len;
  logic       cmd_mode;
  logic       cmd_corrupt;
  logic       busy;
  logic       pkt_valid;
  logic [7:0] pkt_data;
  logic       ready;
  logic       done;
  logic       cmd_err;
  logic [15:0] pkt_count;

  router_pkt_src #(
    .DATA_WIDTH(8), .ADDR_WIDTH(2),
    .NUM_DEST(NUM_DEST), .GAP_CYCLES(GAP),
    .SEED(SEED)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .cmd_mode(cmd_mode), .cmd_corrupt(cmd_corrupt),
    .busy(busy), .pkt_valid(pkt_valid),
    .pkt_data(pkt_data), .ready(ready), .done(done),
    .cmd_err(cmd_err), .pkt_count(pkt_count)
  );

  always #5 clock = ~clock;

  int errs   = 0;
  int checks = 0;

  // Model: the packet as a byte list plus a position in it
  logic [7:0]  m_bytes [0:65];
  int          m_len, m_pos, m_gap;
  logic        m_active;
  logic [15:0] m_lfsr, m_count;
  logic        exp_valid, exp_ready, exp_done, exp_err;
  logic [7:0]  exp_data;
  logic [15:0] exp_count;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_active  = 1'b0;
    m_gap     = 0;
    m_pos     = 0;
    m_len     = 0;
    m_count   = 16'd0;
    m_lfsr    = SEED;
    exp_valid = 1'b0;
    exp_data  = 8'h00;
    exp_ready = 1'b1;
    exp_done  = 1'b0;
    exp_err   = 1'b0;
    exp_count = 16'd0;
  endtask

  task automatic model();
    logic [7:0] b, p;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    if (m_active) begin
      if (!busy) begin
        if (m_pos == m_len + 1) begin
          m_active = 1'b0;
          m_count  = m_count + 16'd1;
          exp_done = 1'b1;
          m_gap    = GAP;
        end else begin
          m_pos++;
        end
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (start) begin
      if (cmd_len == 0 || int'(cmd_addr) >= NUM_DEST) begin
        exp_err = 1'b1;
      end else begin
        m_len      = int'(cmd_len);
        m_bytes[0] = {cmd_len, cmd_addr};
        p          = m_bytes[0];
        for (int k = 1; k <= m_len; k++) begin
          b = cmd_mode ? 8'(k) : m_lfsr[7:0];
          if (!cmd_mode) m_lfsr = lfsr_step(m_lfsr);
          m_bytes[k] = b;
          p = p ^ b;
        end
        m_bytes[m_len+1] = p ^ {7'd0, cmd_corrupt};
        m_active = 1'b1;
        m_pos    = 0;
      end
    end
    exp_valid = m_active && (m_pos <= m_len);
    exp_data  = m_active ? m_bytes[m_pos] : 8'h00;
    exp_ready = !m_active && (m_gap == 0);
    exp_count = m_count;
  endtask

  task automatic compare_all();
    chk("pkt_valid", 32'(pkt_valid), 32'(exp_valid));
    chk("pkt_data",  32'(pkt_data),  32'(exp_data));
    chk("ready",     32'(ready),     32'(exp_ready));
    chk("done",      32'(done),      32'(exp_done));
    chk("cmd_err",   32'(cmd_err),   32'(exp_err));
    chk("pkt_count", 32'(pkt_count), 32'(exp_count));
  endtask

  task automatic tick();
    @(posedge clock);
    if (!reset) model();
    @(negedge clock);
    compare_all();
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 200) begin
      tick();
      n++;
    end
    chk("ready_timeout", 32'(ready), 32'd1);
  endtask

  task automatic issue(input logic [1:0] a, input logic [5:0] l,
                       input logic md, input logic cr);
    cmd_addr    = a;
    cmd_len     = l;
    cmd_mode    = md;
    cmd_corrupt = cr;
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  logic [7:0]  lit1 [0:4];
  logic [15:0] saved;
  int          vcnt;

  initial begin
    lit1[0] = 8'h0E; lit1[1] = 8'h01; lit1[2] = 8'h02;
    lit1[3] = 8'h03; lit1[4] = 8'h0E;
    reset = 1'b1; start = 1'b0; busy = 1'b0;
    cmd_addr = '0; cmd_len = '0;
    cmd_mode = 1'b0; cmd_corrupt = 1'b0;
    model_reset();
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_count", 32'(pkt_count), 32'd0);

    // Incrementing payload, no back-pressure
    issue(2'd2, 6'd3, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("s1_data", 32'(pkt_data), 32'(lit1[i]));
      chk("s1_valid", 32'(pkt_valid), (i < 4) ? 32'd1 : 32'd0);
      tick();
    end
    chk("s1_done", 32'(done), 32'd1);
    chk("s1_count", 32'(pkt_count), 32'd1);
    chk("s1_gap_ready", 32'(ready), 32'd0);
    tick();
    chk("s1_ready", 32'(ready), 32'd1);

    // LFSR payload, 14 bytes
    issue(2'd1, 6'd14, 1'b0, 1'b0);
    chk("s2_header", 32'(pkt_data), 32'h39);
    tick();
    chk("s2_first", 32'(pkt_data), 32'hE1);
    tick();
    chk("s2_second", 32'(pkt_data), 32'h70);
    vcnt = 3;
    repeat (12) begin
      tick();
      if (pkt_valid) vcnt++;
    end
    tick();
    chk("s2_vcnt", 32'(vcnt), 32'd15);
    chk("s2_par_valid", 32'(pkt_valid), 32'd0);
    tick();
    chk("s2_done", 32'(done), 32'd1);
    wait_ready();

    // Busy for 3 cycles while 0x02 is on the bus
    issue(2'd2, 6'd3, 1'b1, 1'b0);
    tick();
    tick();
    chk("s3_b2", 32'(pkt_data), 32'h02);
    busy = 1'b1;
    repeat (3) begin
      tick();
      chk("s3_hold", 32'(pkt_data), 32'h02);
    end
    busy = 1'b0;
    tick();
    chk("s3_b3", 32'(pkt_data), 32'h03);
    tick();
    chk("s3_par", 32'(pkt_data), 32'h0E);
    tick();
    chk("s3_done", 32'(done), 32'd1);
    wait_ready();

    // Corrupted parity
    issue(2'd2, 6'd3, 1'b1, 1'b1);
    repeat (4) tick();
    chk("s4_par", 32'(pkt_data), 32'h0F);
    wait_ready();

    // Rejected commands and start ignored mid-packet
    saved = pkt_count;
    issue(2'd0, 6'd0, 1'b1, 1'b0);
    chk("s5_err_len", 32'(cmd_err), 32'd1);
    tick();
    issue(2'd3, 6'd5, 1'b1, 1'b0);
    chk("s5_err_addr", 32'(cmd_err), 32'd1);
    chk("s5_valid", 32'(pkt_valid), 32'd0);
    chk("s5_count", 32'(pkt_count), 32'(saved));
    tick();
    issue(2'd0, 6'd4, 1'b1, 1'b0);
    start = 1'b1; cmd_len = 6'd9; cmd_addr = 2'd1;
    repeat (5) tick();
    start = 1'b0;
    wait_ready();
    chk("s5_count2", 32'(pkt_count), 32'(saved + 16'd1));

    // Reset during payload byte 5
    issue(2'd0, 6'd10, 1'b0, 1'b0);
    repeat (5) tick();
    chk("s6_pre_valid", 32'(pkt_valid), 32'd1);
    reset = 1'b1;
    #1;
    chk("s6_async_valid", 32'(pkt_valid), 32'd0);
    chk("s6_async_data", 32'(pkt_data), 32'd0);
    model_reset();
    tick();
    reset = 1'b0;
    tick();
    chk("s6_ready", 32'(ready), 32'd1);
    chk("s6_count", 32'(pkt_count), 32'd0);
    issue(2'd0, 6'd2, 1'b0, 1'b0);
    tick();
    chk("s6_first", 32'(pkt_data), 32'hE1);
    wait_ready();

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      start       = ($urandom_range(0, 3) == 0);
      cmd_addr    = 2'($urandom_range(0, 3));
      cmd_len     = 6'($urandom_range(0, 15));
      cmd_mode    = 1'($urandom_range(0, 1));
      cmd_corrupt = 1'($urandom_range(0, 1));
      busy        = ($urandom_range(0, 2) == 0);
      tick();
    end
    start = 1'b0;
    busy  = 1'b0;
    wait_ready();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
